// File: rtl/bht_update_ctrl_pkg.sv
// Shared types and constants for the BHT update controller: RAM word layout,
// sweep value, FSM encoding and the saturating-counter rule.
package bht_update_ctrl_pkg;

  typedef struct packed {
    logic       valid;
    logic [1:0] saturation_counter;
  } bht_t;

  localparam logic [1:0] BHT_FLUSH_CTR = 2'b10;

  localparam logic ST_SWEEP = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  function automatic logic [1:0] bht_sat_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'd1;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_update_ctrl_if.sv
// Update request and BHT RAM port bundle between execute, the update controller and the RAM.
interface bht_update_ctrl_if #(
  parameter int unsigned VLEN  = 32,
  parameter int unsigned IPF   = 2,
  parameter int unsigned ROW_W = 9
);

  logic              flush_bp_i;
  logic              debug_mode_i;
  logic              update_valid_i;
  logic [VLEN-1:0]   update_pc_i;
  logic              update_taken_i;
  logic [ROW_W-1:0]  ram_rd_addr_o;
  logic [IPF*3-1:0]  ram_rdata_i;
  logic [IPF-1:0]    ram_we_o;
  logic [ROW_W-1:0]  ram_waddr_o;
  logic [IPF*3-1:0]  ram_wdata_o;
  logic              busy_o;
  logic              drop_o;

  modport master (
    output flush_bp_i, debug_mode_i, update_valid_i, update_pc_i, update_taken_i, ram_rdata_i,
    input  ram_rd_addr_o, ram_we_o, ram_waddr_o, ram_wdata_o, busy_o, drop_o
  );

  modport slave (
    input  flush_bp_i, debug_mode_i, update_valid_i, update_pc_i, update_taken_i, ram_rdata_i,
    output ram_rd_addr_o, ram_we_o, ram_waddr_o, ram_wdata_o, busy_o, drop_o
  );

endinterface

// File: rtl/bht_update_ctrl_fifo.sv
// Small power-of-two FIFO holding pending BHT updates; flush has priority over push/pop.
module bht_update_ctrl_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_cnt;

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_cnt == CntW'(Depth));
  assign o_empty = (r_cnt == '0);

  // A push while full is only issued alongside a pop, so the slot being
  // overwritten is the head that is leaving this cycle.
  always_ff @(posedge clk_i) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!i_push && i_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// Owns the BHT RAM write port: invalidation sweep after reset/flush, then
// read-modify-write saturating-counter updates drained from a pending queue.
module bht_update_ctrl
  import bht_update_ctrl_pkg::*;
#(
  parameter int unsigned VLEN       = 32,
  parameter int unsigned IPF        = 2,
  parameter bit          RVC        = 1'b1,
  parameter bit          DebugEn    = 1'b1,
  parameter int unsigned NR_ENTRIES = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             clk_i,
  input logic             rst_ni,
  bht_update_ctrl_if.slave bus
);

  localparam int unsigned NR_ROWS       = NR_ENTRIES / IPF;
  localparam int unsigned ROW_W         = $clog2(NR_ROWS);
  localparam int unsigned OFFSET        = RVC ? 1 : 2;
  localparam int unsigned ROW_ADDR_BITS = $clog2(IPF);
  localparam int unsigned COL_W         = (IPF > 1) ? ROW_ADDR_BITS : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NR_ROWS - 1);
  localparam logic [2:0] SWEEP_WORD     = {1'b0, BHT_FLUSH_CTR};

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             taken;
  } bht_update_req_t;

  logic             r_state;
  logic [ROW_W-1:0] r_sweep_cnt;
  logic             r_b_valid;
  bht_update_req_t  r_b;
  logic             r_lw_valid;
  logic [ROW_W-1:0] r_lw_row;
  logic [COL_W-1:0] r_lw_col;
  logic [1:0]       r_lw_ctr;

  bht_update_req_t  w_req;
  bht_update_req_t  w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_push_ok;
  logic             w_pop;
  logic             w_b_write;
  logic [1:0]       w_old_ram;
  logic [1:0]       w_old;
  logic [1:0]       w_new;
  logic [IPF-1:0]   w_we;
  logic [ROW_W-1:0] w_waddr;
  logic [IPF*3-1:0] w_wdata;
  logic             w_unused;

  assign w_unused = ^{bus.update_pc_i, bus.ram_rdata_i};

  always_comb begin
    w_req       = '0;
    w_req.row   = bus.update_pc_i[ROW_ADDR_BITS+OFFSET +: ROW_W];
    w_req.taken = bus.update_taken_i;
    if (RVC && IPF > 1) begin
      w_req.col = bus.update_pc_i[OFFSET +: COL_W];
    end
  end

  assign w_push    = bus.update_valid_i & ~(DebugEn & bus.debug_mode_i) & ~bus.flush_bp_i;
  assign w_pop     = (r_state == ST_RUN) & ~w_empty & ~bus.flush_bp_i;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_b_write = r_b_valid & ~bus.flush_bp_i;

  // Cleared on the flush edge itself so the first sweep cycle starts empty.
  bht_update_ctrl_fifo #(
    .Width ($bits(bht_update_req_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_flush (bus.flush_bp_i),
    .i_push  (w_push_ok),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_old_ram = '0;
    for (int c = 0; c < IPF; c++) begin
      if (r_b.col == c[COL_W-1:0]) begin
        w_old_ram = bus.ram_rdata_i[c*3 +: 2];
      end
    end
  end

  // The RAM returns pre-write data when the previous cycle wrote the same entry.
  assign w_old = (r_lw_valid && r_lw_row == r_b.row && r_lw_col == r_b.col) ? r_lw_ctr
                                                                             : w_old_ram;
  assign w_new = bht_sat_next(w_old, r_b.taken);

  always_comb begin
    w_we    = '0;
    w_waddr = '0;
    w_wdata = '0;
    if (r_state == ST_SWEEP) begin
      // Held off while reset is asserted so the port is quiet during reset.
      if (rst_ni) begin
        w_we    = '1;
        w_waddr = r_sweep_cnt;
        w_wdata = {IPF{SWEEP_WORD}};
      end
    end else if (w_b_write) begin
      w_waddr = r_b.row;
      for (int c = 0; c < IPF; c++) begin
        if (r_b.col == c[COL_W-1:0]) begin
          w_we[c]          = 1'b1;
          w_wdata[c*3 +: 3] = {1'b1, w_new};
        end
      end
    end
  end

  assign bus.ram_we_o      = w_we;
  assign bus.ram_waddr_o   = w_waddr;
  assign bus.ram_wdata_o   = w_wdata;
  assign bus.ram_rd_addr_o = w_pop ? w_head.row : '0;
  assign bus.busy_o        = (r_state == ST_SWEEP);
  assign bus.drop_o        = w_push & ~w_push_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_SWEEP;
      r_sweep_cnt <= '0;
      r_b_valid   <= 1'b0;
      r_b         <= '0;
      r_lw_valid  <= 1'b0;
      r_lw_row    <= '0;
      r_lw_col    <= '0;
      r_lw_ctr    <= '0;
    end else if (bus.flush_bp_i) begin
      r_state     <= ST_SWEEP;
      r_sweep_cnt <= '0;
      r_b_valid   <= 1'b0;
      r_lw_valid  <= 1'b0;
    end else begin
      if (r_state == ST_SWEEP) begin
        r_sweep_cnt <= r_sweep_cnt + 1'b1;
        if (r_sweep_cnt == LAST_ROW) r_state <= ST_RUN;
      end
      r_b_valid <= w_pop;
      if (w_pop) r_b <= w_head;
      r_lw_valid <= w_b_write;
      if (w_b_write) begin
        r_lw_row <= r_b.row;
        r_lw_col <= r_b.col;
        r_lw_ctr <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Bench for bht_update_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a queue-based model of the update rules.
module tb_bht_update_ctrl;

  localparam int unsigned VLEN       = 32;
  localparam int unsigned IPF        = 2;
  localparam int unsigned NR_ENTRIES = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned NR_ROWS    = 8;
  localparam int unsigned ROW_W      = 3;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  bht_update_ctrl_if #(.VLEN(VLEN), .IPF(IPF), .ROW_W(ROW_W)) bus ();

  bht_update_ctrl #(
    .VLEN       (VLEN),
    .IPF        (IPF),
    .RVC        (1'b1),
    .DebugEn    (1'b1),
    .NR_ENTRIES (NR_ENTRIES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  // Read-first synchronous RAM, plus a side door for preloading entries.
  logic [IPF*3-1:0] mem [NR_ROWS];
  logic             pre_en = 1'b0;
  logic [ROW_W-1:0] pre_row = '0;
  int               pre_col = 0;
  logic [2:0]       pre_val = '0;

  always @(posedge clk) begin
    bus.ram_rdata_i <= mem[bus.ram_rd_addr_o];
    for (int c = 0; c < IPF; c++) begin
      if (bus.ram_we_o[c]) mem[bus.ram_waddr_o][c*3 +: 3] <= bus.ram_wdata_o[c*3 +: 3];
    end
    if (pre_en) mem[pre_row][pre_col*3 +: 3] <= pre_val;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: entry counters, pending queue, in-flight update, sweep row.
  typedef struct {
    int row;
    int col;
    bit taken;
  } upd_t;

  upd_t q[$];
  upd_t infl;
  bit   infl_v = 1'b0;
  int   sweep_row = 0;
  int   m_ctr [NR_ROWS][IPF];

  bit          in_v = 1'b0;
  logic [31:0] in_pc = '0;
  bit          in_tk = 1'b0;
  bit          in_fl = 1'b0;
  bit          in_dbg = 1'b0;

  task automatic drive(input bit v, input logic [31:0] pc, input bit tk, input bit fl,
                       input bit dbg);
    in_v = v; in_pc = pc; in_tk = tk; in_fl = fl; in_dbg = dbg;
    bus.update_valid_i = v;
    bus.update_pc_i    = pc;
    bus.update_taken_i = tk;
    bus.flush_bp_i     = fl;
    bus.debug_mode_i   = dbg;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic preload(input int row, input int col, input int ctr);
    pre_en  = 1'b1;
    pre_row = ROW_W'(row);
    pre_col = col;
    pre_val = {1'b1, 2'(ctr)};
    m_ctr[row][col] = ctr;
  endtask

  task automatic model_step();
    bit          sweeping, push, pop, drop;
    logic [1:0]  exp_we;
    int          exp_waddr, exp_rd, old, new_ctr, ccol;
    upd_t        u;
    sweeping  = (sweep_row >= 0);
    push      = in_v && !in_dbg && !in_fl;
    pop       = !sweeping && (q.size() > 0) && !in_fl;
    drop      = push && (q.size() == FIFO_DEPTH) && !pop;
    exp_rd    = pop ? q[0].row : 0;
    exp_we    = 2'b00;
    exp_waddr = 0;
    new_ctr   = 0;
    ccol      = 0;
    if (sweeping) begin
      exp_we    = 2'b11;
      exp_waddr = sweep_row;
    end else if (infl_v && !in_fl) begin
      ccol = infl.col;
      old  = m_ctr[infl.row][ccol];
      if (infl.taken) new_ctr = (old == 3) ? 3 : old + 1;
      else            new_ctr = (old == 0) ? 0 : old - 1;
      exp_we    = 2'(1 << ccol);
      exp_waddr = infl.row;
    end
    check_eq("we", 32'(bus.ram_we_o), 32'(exp_we));
    check_eq("waddr", 32'(bus.ram_waddr_o), 32'(exp_waddr));
    check_eq("rd_addr", 32'(bus.ram_rd_addr_o), 32'(exp_rd));
    check_eq("busy", 32'(bus.busy_o), 32'(sweeping));
    check_eq("drop", 32'(bus.drop_o), 32'(drop));
    for (int c = 0; c < IPF; c++) begin
      if (exp_we[c]) begin
        check_eq("wdata", 32'(bus.ram_wdata_o[c*3 +: 3]),
                 sweeping ? 32'h2 : 32'(4 + new_ctr));
      end
    end
    if (sweeping) begin
      for (int c = 0; c < IPF; c++) m_ctr[sweep_row][c] = 2;
    end else if (exp_we != 2'b00) begin
      m_ctr[infl.row][ccol] = new_ctr;
    end
    if (in_fl) begin
      q.delete();
      infl_v    = 1'b0;
      sweep_row = 0;
    end else begin
      if (sweeping) begin
        sweep_row++;
        if (sweep_row == NR_ROWS) sweep_row = -1;
      end
      infl_v = pop;
      if (pop) infl = q.pop_front();
      if (push && !drop) begin
        u.row   = (in_pc / 4) % NR_ROWS;
        u.col   = (in_pc / 2) % IPF;
        u.taken = in_tk;
        q.push_back(u);
      end
    end
  endtask

  task automatic tick();
    #1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    #1;
    check_eq("rst_we", 32'(bus.ram_we_o), 32'h0);
    check_eq("rst_wdata", 32'(bus.ram_wdata_o), 32'h0);
    check_eq("rst_rd_addr", 32'(bus.ram_rd_addr_o), 32'h0);
    check_eq("rst_waddr", 32'(bus.ram_waddr_o), 32'h0);
    check_eq("rst_drop", 32'(bus.drop_o), 32'h0);
    check_eq("rst_busy", 32'(bus.busy_o), 32'h1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    q.delete();
    infl_v    = 1'b0;
    sweep_row = 0;
    rst_ni    = 1'b1;
  endtask

  task automatic wait_sweep_done(input string tag, input int exp_len);
    int n;
    n = 0;
    while (bus.busy_o && n < 40) begin
      tick();
      idle();
      n++;
    end
    check_eq(tag, 32'(n), 32'(exp_len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.ram_rdata_i = '0;
    do_reset();

    // Sweep after reset: eight busy cycles writing rows 0..7.
    wait_sweep_done("reset_sweep_len", 8);
    #1 check_eq("busy_after_sweep", 32'(bus.busy_o), 32'h0);

    // Single taken update to row 1 col 0 whose stored value is {1, 2'b10}.
    preload(1, 0, 2);
    drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1 check_eq("one_rd_addr", 32'(bus.ram_rd_addr_o), 32'h1);
    tick();
    #1;
    check_eq("one_we", 32'(bus.ram_we_o), 32'h1);
    check_eq("one_waddr", 32'(bus.ram_waddr_o), 32'h1);
    check_eq("one_wdata", 32'(bus.ram_wdata_o[2:0]), 32'h7);
    tick();

    // Back-to-back updates to row 1 col 1 starting from counter 2'b01.
    preload(1, 1, 1);
    drive(1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    check_eq("b2b_we0", 32'(bus.ram_we_o), 32'h2);
    check_eq("b2b_wdata0", 32'(bus.ram_wdata_o[5:3]), 32'h6);
    tick();
    #1;
    check_eq("b2b_we1", 32'(bus.ram_we_o), 32'h2);
    check_eq("b2b_wdata1", 32'(bus.ram_wdata_o[5:3]), 32'h7);
    tick();

    // Queue three during a sweep, flush again, then one update during the new sweep.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h12, 1'b0, 1'b0, 1'b0);
    wait_sweep_done("flush_sweep_len", 8);
    repeat (3) tick();

    // Five pushes during a sweep: the fifth overflows.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(2 * i + 4), i[0], 1'b0, 1'b0);
      if (i == 4) #1 check_eq("drop_fifth", 32'(bus.drop_o), 32'h1);
      tick();
    end
    idle();
    wait_sweep_done("ovf_sweep_len", 3);
    repeat (6) tick();

    // Debug mode suppresses updates entirely.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(4 * i), 1'b1, 1'b0, 1'b1);
      #1;
      check_eq("dbg_we", 32'(bus.ram_we_o), 32'h0);
      check_eq("dbg_drop", 32'(bus.drop_o), 32'h0);
      tick();
    end
    idle();
    repeat (3) tick();

    // Random traffic with occasional flush, debug and a mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset();
      end
      drive(($urandom % 3) != 0, $urandom, 1'($urandom), ($urandom % 60) == 0,
            ($urandom % 8) == 0);
      tick();
    end
    idle();
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
